// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state type and default timing constants for the FIFO-fed UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DEFAULT_CLK_FREQ = 100_000_000;
    localparam int DEFAULT_BAUD     = 9600;

endpackage

// File: rtl/baud_gen.sv
// rtl/baud_gen.sv - bit-period counter producing one tick per BIT_CYC enabled cycles
module baud_gen #(
    parameter int BIT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(BIT_CYC);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

    logic [CW-1:0] cnt;

    // Tick marks the last cycle of the current bit period; only meaningful while enabled.
    assign tick = en && (cnt == LAST);

    // Count 0..BIT_CYC-1 while enabled, restart from zero on clear so a new frame starts aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter that pops bytes from an upstream FIFO and serialises them 8N1
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD       = DEFAULT_BAUD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_re,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int BW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    generate
        if (BIT_CYC < 2) begin : g_bit_cyc_too_small
            $error("fifo_uart_tx: CLK_FREQ/BAUD must be at least 2");
        end
    endgenerate

    state_t                state;
    state_t                state_nx;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] sh_nx;
    logic [BW-1:0]         bit_cnt;
    logic [BW-1:0]         bit_cnt_nx;
    logic                  tx_nx;
    logic                  tick;

    // Pop only from IDLE; masked during reset so nothing is consumed while the block is held.
    assign fifo_re = (state == IDLE) && !fifo_empty && !rst;
    assign tx_busy = (state != IDLE);

    baud_gen #(
        .BIT_CYC (BIT_CYC)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (fifo_re),
        .en   (tx_busy),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, shifter and bit-counter update; each phase advances only on the baud tick.
    always_comb begin
        state_nx   = state;
        sh_nx      = sh;
        bit_cnt_nx = bit_cnt;
        case (state)
            IDLE: begin
                if (fifo_re) begin
                    state_nx   = START;
                    sh_nx      = fifo_rdata;
                    bit_cnt_nx = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    sh_nx      = sh >> 1;
                    bit_cnt_nx = bit_cnt + BW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Line level is derived from the upcoming state so the registered tx lines up with the state it belongs to.
    always_comb begin
        tx_nx = 1'b1;
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = sh_nx[0];
            default: tx_nx = 1'b1;
        endcase
    end

    // Datapath registers and the end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh      <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            sh      <= sh_nx;
            bit_cnt <= bit_cnt_nx;
            tx      <= tx_nx;
            tx_done <= (state == STOP) && tick;
        end
    end

endmodule
